// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM state encoding used by serial_subtractor.
package sub_pkg;

    // FSM states; the unused encoding 2'd3 is steered back to IDLE by the top.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width able to hold 0..width without wrapping.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin (mod 2), bout = borrow out.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
module bit_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor computing A - B - BIN, LSB first, one bit
// per clock, with valid/ready handshakes on both the operand and result side.
// Ports:
//   clk        in  rising-edge clock
//   rst        in  asynchronous active-high reset
//   in_valid   in  operand set valid
//   in_ready   out block can accept operands (IDLE only)
//   in_a       in  minuend
//   in_b       in  subtrahend
//   in_bin     in  borrow into bit 0
//   out_valid  out result valid (DONE only)
//   out_ready  in  consumer accepts result
//   out_diff   out difference modulo 2^WIDTH, held until the next result
//   out_bout   out borrow out of the MSB
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bo;
    logic [WIDTH-1:0] d_next;

    // The single arithmetic stage, fed from the LSBs of the operand shifters.
    bit_full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .d    (d),
        .bout (bo)
    );

    // New difference bit enters at the MSB; written this way so WIDTH=1 works.
    assign d_next = WIDTH'({d, d_sh} >> 1);

    // FSM, datapath shifters and registered handshake/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_diff  <= '0;
            out_bout  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            d_sh      <= '0;
            brw       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= in_a;
                        b_sh     <= in_b;
                        brw      <= in_bin;
                        cnt      <= '0;
                        d_sh     <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    d_sh <= d_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    brw  <= bo;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out_diff  <= d_next;
                        out_bout  <= bo;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
